// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// divide-by-zero fill value and the counter sizing helper.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_ITER,
    S_DIV_FIX
  } mdu_state_e;

  // Quotient fill on divide-by-zero; the remainder already equals the dividend.
  localparam logic DZ_QUOT_BIT = 1'b1;

  function automatic int cnt_width(input int mul_lat, input int width);
    int m;
    m = (mul_lat > width) ? mul_lat : width;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned radix-2 restoring divider: load latches operands, each step retires one
// quotient bit MSB-first. Sign handling lives in the parent.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Dividend bits shift out of r_quot into the partial remainder as quotient bits shift in.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[WIDTH-1:0] - r_div;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_load) begin
      r_div  <= i_divisor;
      r_rem  <= '0;
      r_quot <= i_dividend;
    end else if (i_step) begin
      r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quot <= {r_quot[WIDTH-2:0], w_ge};
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_iterative.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency multiply, restoring
// divide, MTHI/MTLO, Busy for stall logic and abort on exception flush.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start_E,
  input  logic [2:0]       MDOp_E,
  input  logic [WIDTH-1:0] SrcA_E,
  input  logic [WIDTH-1:0] SrcB_E,
  input  logic             Abort_E,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int            CW       = cnt_width(MUL_LAT, WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  mdu_state_e         r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_q_neg, r_r_neg, r_div_zero;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  md_op_e             w_op;
  logic               w_start, w_signed_op, w_neg_a, w_neg_b;
  logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_quot_fix, w_rem_fix;
  logic               w_mul_go, w_div_go, w_step, w_cnt_inc;
  logic               w_wr_mul, w_wr_div, w_wr_hi, w_wr_lo;

  assign w_op        = md_op_e'(MDOp_E);
  assign w_start     = (r_state == S_IDLE) && Start_E && !Abort_E;
  assign w_signed_op = (w_op == MD_MULT) || (w_op == MD_DIV);

  // Extending to 2*WIDTH before multiplying gives the exact signed or unsigned product.
  assign w_ext_a = w_signed_op ? {{WIDTH{SrcA_E[WIDTH-1]}}, SrcA_E} : {{WIDTH{1'b0}}, SrcA_E};
  assign w_ext_b = w_signed_op ? {{WIDTH{SrcB_E[WIDTH-1]}}, SrcB_E} : {{WIDTH{1'b0}}, SrcB_E};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_neg_a = w_signed_op && SrcA_E[WIDTH-1];
  assign w_neg_b = w_signed_op && SrcB_E[WIDTH-1];
  assign w_abs_a = w_neg_a ? -SrcA_E : SrcA_E;
  assign w_abs_b = w_neg_b ? -SrcB_E : SrcB_E;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_div_go),
    .i_step     (w_step),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_quot_fix = r_q_neg ? -w_quot : w_quot;
  assign w_rem_fix  = r_r_neg ? -w_rem  : w_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_next    = r_state;
    w_mul_go  = 1'b0;
    w_div_go  = 1'b0;
    w_step    = 1'b0;
    w_cnt_inc = 1'b0;
    w_wr_mul  = 1'b0;
    w_wr_div  = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          case (w_op)
            MD_MULT, MD_MULTU: begin w_mul_go = 1'b1; w_next = S_MUL_WAIT; end
            MD_DIV, MD_DIVU:   begin w_div_go = 1'b1; w_next = S_DIV_ITER; end
            MD_MTHI:           w_wr_hi = 1'b1;
            MD_MTLO:           w_wr_lo = 1'b1;
            default:           ;
          endcase
        end
      end
      S_MUL_WAIT: begin
        if (r_cnt == MUL_LAST) begin w_wr_mul = 1'b1; w_next = S_IDLE; end
        else w_cnt_inc = 1'b1;
      end
      S_DIV_ITER: begin
        w_step = 1'b1;
        if (r_cnt == DIV_LAST) w_next = S_DIV_FIX;
        else w_cnt_inc = 1'b1;
      end
      S_DIV_FIX: begin
        w_wr_div = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Flush beats everything, including the final HI/LO write.
    if (Abort_E) begin
      w_next    = S_IDLE;
      w_step    = 1'b0;
      w_cnt_inc = 1'b0;
      w_wr_mul  = 1'b0;
      w_wr_div  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_prod     <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_wr_mul || w_wr_div;
      if (w_mul_go || w_div_go || Abort_E) r_cnt <= '0;
      else if (w_cnt_inc)                  r_cnt <= r_cnt + CW'(1);
      if (w_mul_go) r_prod <= w_prod;
      if (w_div_go) begin
        r_q_neg    <= w_neg_a ^ w_neg_b;
        r_r_neg    <= w_neg_a;
        r_div_zero <= (SrcB_E == '0);
      end
      if (w_wr_mul) begin
        {r_hi, r_lo} <= r_prod;
      end else if (w_wr_div) begin
        r_hi <= w_rem_fix;
        r_lo <= r_div_zero ? {WIDTH{DZ_QUOT_BIT}} : w_quot_fix;
      end else begin
        if (w_wr_hi) r_hi <= SrcA_E;
        if (w_wr_lo) r_lo <= SrcA_E;
      end
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus random ops
// against an arithmetic reference model of HI/LO and operation latency.
module tb_mdu_iterative;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = W + 1;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          Start_E = 1'b0;
  logic          Abort_E = 1'b0;
  logic [2:0]    MDOp_E = '0;
  logic [W-1:0]  SrcA_E = '0;
  logic [W-1:0]  SrcB_E = '0;
  logic          Busy, Done;
  logic [W-1:0]  HI, LO;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  mdu_iterative #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start_E (Start_E),
    .MDOp_E  (MDOp_E),
    .SrcA_E  (SrcA_E),
    .SrcB_E  (SrcB_E),
    .Abort_E (Abort_E),
    .Busy    (Busy),
    .Done    (Done),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics in plain arithmetic; returns latency (0 = immediate/no-op).
  function automatic int model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               inout logic [W-1:0] hi, inout logic [W-1:0] lo);
    longint    sa, sb;
    logic [63:0] p;
    sa = int'(a);
    sb = int'(b);
    case (op)
      OP_MULT:  begin p = sa * sb; {hi, lo} = p; return ML; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; return ML; end
      OP_DIV: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin lo = a; hi = '0; end
        else begin lo = int'(a) / int'(b); hi = int'(a) % int'(b); end
        return DL;
      end
      OP_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
        return DL;
      end
      OP_MTHI: begin hi = a; return 0; end
      OP_MTLO: begin lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Called at a negedge. abort_at/intrude_at: busy-cycle number at which to flush / re-Start.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int abort_at, input int intrude_at);
    logic [W-1:0] ehi, elo;
    int           lat, cyc;
    string        nm;
    ehi = m_hi;
    elo = m_lo;
    lat = model(op, a, b, ehi, elo);
    nm  = $sformatf("op%0d(%0h,%0h)", op, a, b);
    Start_E = 1'b1; MDOp_E = op; SrcA_E = a; SrcB_E = b;
    @(negedge clk);
    Start_E = 1'b0; MDOp_E = 3'($urandom); SrcA_E = $urandom; SrcB_E = $urandom;
    if (lat == 0) begin
      check({nm, " busy"}, Busy, 1'b0);
      check({nm, " done"}, Done, 1'b0);
      m_hi = ehi; m_lo = elo;
    end else begin
      cyc = 0;
      while (Busy && cyc < 200) begin
        cyc++;
        Start_E = (cyc == intrude_at);
        if (cyc == intrude_at) begin MDOp_E = OP_MULT; SrcA_E = $urandom; SrcB_E = $urandom; end
        Abort_E = (cyc == abort_at);
        @(negedge clk);
      end
      Start_E = 1'b0; Abort_E = 1'b0;
      if (abort_at > 0) begin
        check({nm, " abort_busy_len"}, cyc, abort_at);
        check({nm, " abort_done"}, Done, 1'b0);
      end else begin
        check({nm, " busy_len"}, cyc, lat);
        check({nm, " done"}, Done, 1'b1);
        m_hi = ehi; m_lo = elo;
      end
    end
    check({nm, " hi"}, HI, m_hi);
    check({nm, " lo"}, LO, m_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset hi", HI, 0);
    check("reset lo", LO, 0);
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_op(OP_MTLO, 32'hfab6_e829, 32'h0, 0, 0);
    do_op(OP_MTHI, 32'h0, 32'h0, 0, 0);
    do_op(OP_MULT, 32'hffff_ffff, 32'h2, 0, 0);
    @(negedge clk);
    check("done one cycle", Done, 0);
    do_op(OP_MULTU, 32'hffff_ffff, 32'h2, 0, 0);
    do_op(OP_DIV,  32'hffff_fff9, 32'h2, 0, 0);
    do_op(OP_DIVU, 32'hfab6_e829, 32'h10, 0, 0);
    do_op(OP_DIV,  32'h8000_0000, 32'hffff_ffff, 0, 0);
    do_op(OP_DIVU, 32'hfab6_e829, 32'h0, 0, 0);
    do_op(OP_DIV,  32'hffff_fff9, 32'h0, 0, 0);
    do_op(OP_DIV,  32'h7, 32'hffff_fffe, 0, 0);

    // Flush mid-divide, on the final divide edge, and on the final multiply edge.
    do_op(OP_DIV,  32'h1234_5678, 32'h3, 10, 0);
    do_op(OP_DIVU, 32'hdead_beef, 32'h7, DL, 0);
    do_op(OP_MULT, 32'h0bad_cafe, 32'h9, ML, 0);

    // Start and Abort in the same cycle: nothing starts, HI/LO untouched.
    Start_E = 1'b1; Abort_E = 1'b1; MDOp_E = OP_DIV; SrcA_E = 32'h64; SrcB_E = 32'h5;
    @(negedge clk);
    MDOp_E = OP_MTLO; SrcA_E = 32'h5555_aaaa;
    @(negedge clk);
    Start_E = 1'b0; Abort_E = 1'b0;
    check("start+abort busy", Busy, 0);
    check("start+abort lo", LO, m_lo);
    check("start+abort hi", HI, m_hi);

    // Start while busy is ignored.
    do_op(OP_DIV, 32'hffff_ff9c, 32'h7, 0, 3);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op(op, pick(), pick(), 0, 0);
    end

    // Asynchronous reset in the middle of a multiply.
    do_op(OP_MTHI, 32'h1357_9bdf, 32'h0, 0, 0);
    do_op(OP_MTLO, 32'h2468_ace0, 32'h0, 0, 0);
    Start_E = 1'b1; MDOp_E = OP_MULT; SrcA_E = 32'h1234; SrcB_E = 32'h5678;
    @(negedge clk);
    Start_E = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset hi", HI, 0);
    check("midreset lo", LO, 0);
    check("midreset busy", Busy, 0);
    check("midreset done", Done, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op(OP_MULTU, $urandom, $urandom, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core, sitting beside the ALU and owning the HI/LO registers. It executes MULT/MULTU with a configurable fixed latency and DIV/DIVU as a radix-2 restoring iteration. It also services MTHI/MTLO, drives Busy for the hazard unit's stall logic, and supports abort on exception flush.

Parameters:
WIDTH, 32, operand/HI/LO width (≥4, even)
MUL_LAT, 5, cycles from Start sample to HI/LO update for multiply (≥1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
Start_E  in  1  request; qualifies MDOp_E/SrcA_E/SrcB_E this cycle
MDOp_E  in  3  op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (NONE)
SrcA_E  in  WIDTH  operand A / dividend / MTHI-MTLO data
SrcB_E  in  WIDTH  operand B / divisor
Abort_E  in  1  cancel in-flight op (exception flush)
Busy  out  1  multi-cycle op in flight
Done  out  1  one-cycle pulse after HI/LO written by MULT/DIV
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register

Behaviour:
- Reset (async, reset_n=0): state IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0, operand/partial registers 0. Reset mid-operation discards the op; no HI/LO write.
- States: IDLE, MUL_WAIT, DIV_ITER, DIV_FIX.
- Start sampled only in IDLE with Abort_E=0; Start_E while Busy=1 ignored (hazard unit guarantees none).
- Timing: Start sampled at edge E0. Multi-cycle op → Busy=1 from after E0 until after edge E0+L; HI/LO written at E0+L; Busy falls and Done=1 for the cycle following E0+L. Back-to-back Start legal in that Done cycle.
- MULT/MULTU: L=MUL_LAT. At E0 capture full 2·WIDTH product (signed for MULT, unsigned for MULTU) into an internal register; count MUL_LAT-1 cycles in MUL_WAIT; at E0+L {HI,LO}=product. MUL_LAT=1 → write directly at edge after E0 (skip MUL_WAIT).
- DIV/DIVU: L=WIDTH+1. At E0: latch |A|,|B| (DIV) or raw (DIVU), record quotient/remainder sign flags (q neg = signA^signB, r neg = signA). DIV_ITER: WIDTH restoring steps, one quotient bit per edge MSB-first. DIV_FIX (1 edge): apply sign fixups, write LO=quotient, HI=remainder.
- Division by zero: full latency, LO=all ones, HI=SrcA (dividend unchanged), both DIV and DIVU.
- Signed overflow (DIV, A=min negative, B=-1): LO=min negative (0x80000000), HI=0; falls out of abs/negate naturally, must be checked.
- Remainder sign follows dividend; quotient truncates toward zero.
- MTHI/MTLO: in IDLE, write HI/LO at E0; Busy stays 0, Done stays 0. Ignored if Busy.
- NONE/reserved with Start_E: no effect.
- Abort_E=1: synchronous; any state → IDLE next edge, Busy=0, Done=0, HI/LO unchanged. Abort_E and Start_E same cycle → abort wins, Start dropped. Abort in the final cycle (edge E0+L) wins: no HI/LO write.
- Operands captured at E0; SrcA_E/SrcB_E changes afterwards have no effect.
- Counter width clog2(max(MUL_LAT,WIDTH)+1); no wrap beyond terminal count.

Decomposition:
- Package mdu_pkg: MDOp encodings (MD_NONE…MD_MTLO), state enum, div-by-zero result constants.
- One sub-module: mdu_div_core — iterative restoring divider (load, step, done), unsigned only; sign handling and HI/LO ownership stay in mdu_iterative.

Test Plan:
- Reset then MTLO SrcA=0xfab6e829, MTHI SrcA=0 → LO=0xfab6e829, HI=0 one edge later, Busy never high.
- MULT A=0xFFFFFFFF B=2 → Busy 5 cycles, HI=0xFFFFFFFF LO=0xFFFFFFFE, Done one cycle; MULTU same operands → HI=0x00000001 LO=0xFFFFFFFE.
- DIV A=-7 (0xFFFFFFF9) B=2 → after 33 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=0xfab6e829 B=0x10 → LO=0x0fab6e82, HI=0x00000009.
- DIV A=0x80000000 B=0xFFFFFFFF → LO=0x80000000, HI=0; DIVU A=0xfab6e829 B=0 → LO=0xFFFFFFFF, HI=0xfab6e829.
- DIV in flight, Abort_E at cycle 10 → Busy low next cycle, Done never pulses, HI/LO hold prior values; Start_E+Abort_E same cycle → no op starts.
- Start_E with MULT while Busy (DIV in flight) → ignored, DIV result correct; reset_n low mid-MULT → HI=LO=0, Busy=0 immediately.
